collision_map_writer: RTL and testbench

COLLISION_MAP_WRITER -- requirements
Module: collision_map_writer

---
 rtl/collision_map_writer_if.sv | 27 ++
 rtl/collision_map_writer.sv | 148 ++++++++++++++
 tb/tb_collision_map_writer.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/collision_map_writer_if.sv
// Request/write-port bundle for collision_map_writer: rectangle job request in,
// collision-RAM write strobe and job status out.
interface collision_map_writer_if;
  logic        start;
  logic [9:0]  rect_left;
  logic [9:0]  rect_right;
  logic [9:0]  rect_top;
  logic [9:0]  rect_bottom;
  logic [2:0]  fill_value;
  logic        hold;
  logic        wr_en;
  logic [18:0] wr_addr;
  logic [2:0]  wr_data;
  logic        busy;
  logic        done;
  logic        err;

  modport master (
    output start, rect_left, rect_right, rect_top, rect_bottom, fill_value, hold,
    input  wr_en, wr_addr, wr_data, busy, done, err
  );

  modport slave (
    input  start, rect_left, rect_right, rect_top, rect_bottom, fill_value, hold,
    output wr_en, wr_addr, wr_data, busy, done, err
  );
endinterface

// File: rtl/collision_map_writer.sv
// Fills an inclusive rectangle of the collision map with one code, row-major.
// Define BOUNDS_CLIP_EN to clip off-screen rectangles instead of rejecting them.
module collision_map_writer #(
  parameter int H_RES = 640,
  parameter int V_RES = 480
) (
  input  logic                   vga_clk,
  input  logic                   Reset,
  collision_map_writer_if.slave  bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] CHECK  = 2'd1;
  localparam logic [1:0] FILL   = 2'd2;
  localparam logic [1:0] FINISH = 2'd3;

  localparam logic [10:0] H_LIM  = 11'(H_RES);
  localparam logic [10:0] V_LIM  = 11'(V_RES);
  localparam logic [18:0] H_STEP = 19'(H_RES);

  logic [1:0]  state_q, state_d;
  logic [9:0]  left_q, left_d, right_q, right_d;
  logic [9:0]  top_q, top_d, bottom_q, bottom_d;
  logic [2:0]  val_q, val_d;
  logic [9:0]  x_q, x_d, y_q, y_d;
  logic [18:0] row_q, row_d;
  logic        reject_q, reject_d;
  logic [18:0] last_addr_q, last_addr_d;
  logic [2:0]  last_data_q, last_data_d;

  logic [9:0]  right_eff, bottom_eff;
  logic        bad;
  logic [18:0] row_init;
  logic [18:0] cur_addr;
  logic        write_w;

  always_comb begin
`ifdef BOUNDS_CLIP_EN
    right_eff  = ({1'b0, right_q}  >= H_LIM) ? 10'(H_RES - 1) : right_q;
    bottom_eff = ({1'b0, bottom_q} >= V_LIM) ? 10'(V_RES - 1) : bottom_q;
    bad = ({1'b0, left_q} >= H_LIM) || ({1'b0, top_q} >= V_LIM) ||
          (left_q > right_eff) || (top_q > bottom_eff);
`else
    right_eff  = right_q;
    bottom_eff = bottom_q;
    bad = ({1'b0, right_q} >= H_LIM) || ({1'b0, bottom_q} >= V_LIM) ||
          (left_q > right_q) || (top_q > bottom_q);
`endif
    // Only multiply once per job; rejected rectangles never use the product.
    row_init = 19'(top_q) * 19'(H_RES);
    cur_addr = row_q + 19'(x_q);
    write_w  = (state_q == FILL) && !bus.hold;
  end

  always_comb begin
    state_d     = state_q;
    left_d      = left_q;
    right_d     = right_q;
    top_d       = top_q;
    bottom_d    = bottom_q;
    val_d       = val_q;
    x_d         = x_q;
    y_d         = y_q;
    row_d       = row_q;
    reject_d    = reject_q;
    last_addr_d = last_addr_q;
    last_data_d = last_data_q;
    case (state_q)
      IDLE: begin
        reject_d = 1'b0;
        if (bus.start) begin
          left_d   = bus.rect_left;
          right_d  = bus.rect_right;
          top_d    = bus.rect_top;
          bottom_d = bus.rect_bottom;
          val_d    = bus.fill_value;
          state_d  = CHECK;
        end
      end
      CHECK: begin
        right_d  = right_eff;
        bottom_d = bottom_eff;
        reject_d = bad;
        x_d      = left_q;
        y_d      = top_q;
        row_d    = row_init;
        state_d  = bad ? FINISH : FILL;
      end
      FILL: begin
        if (write_w) begin
          last_addr_d = cur_addr;
          last_data_d = val_q;
          if (x_q == right_q) begin
            if (y_q == bottom_q) begin
              state_d = FINISH;
            end else begin
              x_d   = left_q;
              y_d   = y_q + 10'd1;
              row_d = row_q + H_STEP;
            end
          end else begin
            x_d = x_q + 10'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      left_q      <= '0;
      right_q     <= '0;
      top_q       <= '0;
      bottom_q    <= '0;
      val_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      row_q       <= '0;
      reject_q    <= 1'b0;
      last_addr_q <= '0;
      last_data_q <= '0;
    end else begin
      state_q     <= state_d;
      left_q      <= left_d;
      right_q     <= right_d;
      top_q       <= top_d;
      bottom_q    <= bottom_d;
      val_q       <= val_d;
      x_q         <= x_d;
      y_q         <= y_d;
      row_q       <= row_d;
      reject_q    <= reject_d;
      last_addr_q <= last_addr_d;
      last_data_q <= last_data_d;
    end
  end

  // Write strobe is combinational so a hold stalls the very cycle it appears in.
  assign bus.wr_en   = write_w;
  assign bus.wr_addr = (state_q == FILL) ? cur_addr : last_addr_q;
  assign bus.wr_data = (state_q == FILL) ? val_q : last_data_q;
  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = (state_q == FINISH);
  assign bus.err     = (state_q == FINISH) && reject_q;

endmodule

// File: tb/tb_collision_map_writer.sv
// Self-checking bench for collision_map_writer: vector table plus address scoreboard.
module tb_collision_map_writer;
  localparam int H = 640;
  localparam int V = 480;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  collision_map_writer_if bus ();

  collision_map_writer #(.H_RES(H), .V_RES(V)) dut (
    .vga_clk (clk),
    .Reset   (rst),
    .bus     (bus)
  );

  typedef struct {
    string       name;
    int          l, r, t, b, v;
    int unsigned hmask;
    int          exp_err, exp_wr, exp_done;
  } vec_t;

  typedef struct {
    logic [18:0] a;
    logic [2:0]  d;
  } exp_t;

  exp_t q[$];
  vec_t tbl[11];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push_model(input int l, input int r, input int t, input int b, input int v);
    int   r2, b2;
    bit   rej;
    exp_t e;
    r2 = r;
    b2 = b;
`ifdef BOUNDS_CLIP_EN
    if (r2 > H - 1) r2 = H - 1;
    if (b2 > V - 1) b2 = V - 1;
    rej = (l >= H) || (t >= V) || (l > r2) || (t > b2);
`else
    rej = (r >= H) || (b >= V) || (l > r) || (t > b);
`endif
    if (!rej)
      for (int y = t; y <= b2; y++)
        for (int x = l; x <= r2; x++) begin
          e.a = 19'(y * H + x);
          e.d = 3'(v);
          q.push_back(e);
        end
  endtask

  task automatic sample_write(inout int nw);
    exp_t e;
    if (bus.wr_en) begin
      nw++;
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL spurious_write: got addr %0d expected no write", bus.wr_addr);
      end else begin
        e = q.pop_front();
        chk("wr_addr", bus.wr_addr, e.a);
        chk("wr_data", bus.wr_data, e.d);
      end
    end
  endtask

  task automatic drive_req(input int l, input int r, input int t, input int b, input int v);
    bus.rect_left   = 10'(l);
    bus.rect_right  = 10'(r);
    bus.rect_top    = 10'(t);
    bus.rect_bottom = 10'(b);
    bus.fill_value  = 3'(v);
    bus.start       = 1'b1;
  endtask

  task automatic run_job(input vec_t tv);
    int          cnt, nw;
    bit          got;
    logic [18:0] last_a;
    cnt = 0; nw = 0; got = 0; last_a = '0;
    push_model(tv.l, tv.r, tv.t, tv.b, tv.v);
    if (q.size() > 0) last_a = q[$].a;
    @(negedge clk);
    drive_req(tv.l, tv.r, tv.t, tv.b, tv.v);
    bus.hold = 1'b0;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
      if (cnt == 1) bus.start = 1'b0;
      bus.hold = (cnt >= 2 && cnt - 2 < 32) ? tv.hmask[cnt-2] : 1'b0;
      #1;
      if (cnt == 1) chk({tv.name, "_busy"}, bus.busy, 1);
      sample_write(nw);
      if (bus.done) begin
        got = 1;
        chk({tv.name, "_done_cycle"}, cnt, tv.exp_done);
        chk({tv.name, "_err"}, bus.err, tv.exp_err);
        chk({tv.name, "_writes"}, nw, tv.exp_wr);
        chk({tv.name, "_leftover"}, q.size(), 0);
      end else if (bus.err) begin
        chk({tv.name, "_err_without_done"}, bus.err, 0);
      end
    end
    bus.hold = 1'b0;
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: got no done expected done at cycle %0d", tv.name, tv.exp_done);
      q.delete();
    end
    @(negedge clk);
    #1;
    chk({tv.name, "_idle_busy"}, bus.busy, 0);
    chk({tv.name, "_idle_wr_en"}, bus.wr_en, 0);
    chk({tv.name, "_idle_done"}, bus.done, 0);
    if (tv.exp_wr > 0) chk({tv.name, "_addr_held"}, bus.wr_addr, last_a);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nw, cnt;
    bit exp_we;

    tbl[0] = '{"basic",      10, 12, 20, 21, 3, 32'h0,   0, 6, 8};
    tbl[1] = '{"hold",       10, 12, 20, 21, 3, 32'h12,  0, 6, 10};
    tbl[2] = '{"lr_swap",    50, 40, 10, 10, 1, 32'h0,   1, 0, 2};
`ifdef BOUNDS_CLIP_EN
    tbl[3] = '{"corner",     638, 700, 478, 500, 5, 32'h0, 0, 4, 6};
    tbl[8] = '{"right_eq_h", 600, 640, 0, 0, 1, 32'h0,   0, 40, 42};
    tbl[9] = '{"bottom_eq_v", 0, 0, 470, 480, 2, 32'h0,  0, 10, 12};
`else
    tbl[3] = '{"corner",     638, 700, 478, 500, 5, 32'h0, 1, 0, 2};
    tbl[8] = '{"right_eq_h", 600, 640, 0, 0, 1, 32'h0,   1, 0, 2};
    tbl[9] = '{"bottom_eq_v", 0, 0, 470, 480, 2, 32'h0,  1, 0, 2};
`endif
    tbl[4] = '{"max_pixel",  639, 639, 479, 479, 7, 32'h0, 0, 1, 3};
    tbl[5] = '{"zero_pixel", 0, 0, 0, 0, 6, 32'h0,       0, 1, 3};
    tbl[6] = '{"tb_swap",    5, 6, 9, 8, 2, 32'h0,       1, 0, 2};
    tbl[7] = '{"wrap_hold",  630, 639, 0, 1, 4, 32'ha05, 0, 20, 26};
    tbl[10] = '{"left_off",  640, 650, 0, 0, 3, 32'h0,   1, 0, 2};

    rst = 1'b1;
    bus.start = 1'b0;
    bus.hold = 1'b0;
    bus.rect_left = '0; bus.rect_right = '0; bus.rect_top = '0; bus.rect_bottom = '0;
    bus.fill_value = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("reset_busy", bus.busy, 0);
    chk("reset_wr_en", bus.wr_en, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_err", bus.err, 0);
    chk("reset_wr_addr", bus.wr_addr, 0);
    chk("reset_wr_data", bus.wr_data, 0);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) run_job(tbl[i]);

    // Reset three writes into a 10x10 fill; the aborted job must not write again.
    push_model(0, 9, 0, 9, 2);
    @(negedge clk);
    drive_req(0, 9, 0, 9, 2);
    nw = 0;
    for (int i = 0; i < 20 && nw < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      #1;
      sample_write(nw);
    end
    chk("abort_writes_before_reset", nw, 3);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_wr_en", bus.wr_en, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_err", bus.err, 0);
    chk("abort_wr_addr", bus.wr_addr, 0);
    chk("abort_wr_data", bus.wr_data, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk("abort_quiet_wr_en", bus.wr_en, 0);
      chk("abort_quiet_done", bus.done, 0);
    end
    q.delete();
    run_job(tbl[0]);

    // start held high: second job only after the FINISH -> IDLE return.
    push_model(1, 2, 1, 1, 4);
    push_model(1, 2, 1, 1, 4);
    @(negedge clk);
    drive_req(1, 2, 1, 1, 4);
    nw = 0;
    cnt = 0;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
      if (cnt == 9) bus.start = 1'b0;
      #1;
      exp_we = (cnt == 2 || cnt == 3 || cnt == 7 || cnt == 8);
      chk("held_wr_en", bus.wr_en, exp_we);
      chk("held_done", bus.done, (cnt == 4 || cnt == 9));
      if (cnt == 5) chk("held_idle_busy", bus.busy, 0);
      if (cnt == 6) chk("held_check_busy", bus.busy, 1);
      sample_write(nw);
    end
    chk("held_writes", nw, 4);
    chk("held_leftover", q.size(), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("held_after_busy", bus.busy, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
